// File: rtl/btn_pulse_gen.sv
// btn_pulse_gen
//
// Turns the three raw push buttons (up, down, centre) into clean one-cycle
// command pulses for the address-sequencing control stage. Each button is
// synchronised, debounced with a consecutive-cycle counter and edge-detected.
// A single arbiter keeps at most one command pulse high per cycle, with
// priority pause > speed_up > speed_down.
//
// Optional feature macro: BTN_AUTO_REPEAT_EN
//   When defined, a held up/down button re-fires after REPEAT_DELAY cycles
//   and then every REPEAT_PERIOD cycles. The centre button never repeats.
//   When undefined, no repeat logic is built and REPEAT_* are unused.
//
// Ports:
//   clk        - system clock, all state on the rising edge
//   Rst_n      - asynchronous active-low reset
//   btn_up     - raw up button, active-high, asynchronous
//   btn_down   - raw down button, active-high, asynchronous
//   btn_center - raw centre button, active-high, asynchronous
//   speed_up   - one-cycle command pulse (up press)
//   speed_down - one-cycle command pulse (down press)
//   pause      - one-cycle command pulse (centre press)
//   btn_level  - debounced levels {center, down, up}

module btn_pulse_gen #(
  parameter int DEBOUNCE_CYCLES = 2_000_000,
  parameter int REPEAT_DELAY    = 50_000_000,
  parameter int REPEAT_PERIOD   = 25_000_000
) (
  input  logic       clk,
  input  logic       Rst_n,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_center,
  output logic       speed_up,
  output logic       speed_down,
  output logic       pause,
  output logic [2:0] btn_level
);

  localparam int MAX_AB     = (DEBOUNCE_CYCLES > REPEAT_DELAY) ? DEBOUNCE_CYCLES : REPEAT_DELAY;
  localparam int MAX_CYCLES = (MAX_AB > REPEAT_PERIOD) ? MAX_AB : REPEAT_PERIOD;
  localparam int CNT_W      = $clog2(MAX_CYCLES) + 1;

  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  // Bit order everywhere is {center, down, up}.
  logic [2:0]       btn_raw;
  logic [2:0]       sync_meta;
  logic [2:0]       sync;
  logic [2:0]       lvl;
  logic [2:0]       lvl_prev;
  logic [CNT_W-1:0] cnt [3];
  logic [2:0]       press_evt;
  logic [2:0]       cand;

  assign btn_raw = {btn_center, btn_down, btn_up};

  // Two-flop synchroniser; only the second stage is used downstream.
  always_ff @(posedge clk or negedge Rst_n) begin
    if (!Rst_n) begin
      sync_meta <= '0;
      sync      <= '0;
    end else begin
      sync_meta <= btn_raw;
      sync      <= sync_meta;
    end
  end

  // Debounce: a new level is accepted only after DEBOUNCE_CYCLES consecutive
  // differing samples. Any matching sample restarts the count, which is what
  // discards short glitches.
  always_ff @(posedge clk or negedge Rst_n) begin
    if (!Rst_n) begin
      lvl <= '0;
      for (int i = 0; i < 3; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (sync[i] == lvl[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == DB_LAST) begin
          lvl[i] <= sync[i];
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + CNT_ONE;
        end
      end
    end
  end

  // Previous debounced level, used to find 0->1 press events.
  always_ff @(posedge clk or negedge Rst_n) begin
    if (!Rst_n) begin
      lvl_prev <= '0;
    end else begin
      lvl_prev <= lvl;
    end
  end

  assign press_evt = lvl & ~lvl_prev;

`ifdef BTN_AUTO_REPEAT_EN
  localparam logic [CNT_W-1:0] RPT_FIRST = CNT_W'(REPEAT_DELAY);
  localparam logic [CNT_W-1:0] RPT_NEXT  = CNT_W'(REPEAT_PERIOD);

  // Repeat timers for up (0) and down (1). The timer counts cycles since the
  // last scheduled candidate (initial press or repeat), regardless of whether
  // the arbiter let it through, so a dropped repeat does not shift the schedule.
  logic [CNT_W-1:0] rpt_cnt [2];
  logic [1:0]       rpt_phase;
  logic [1:0]       rpt_evt;

  always_comb begin
    rpt_evt = '0;
    for (int i = 0; i < 2; i++) begin
      rpt_evt[i] = lvl[i] & lvl_prev[i] &
                   (rpt_cnt[i] == (rpt_phase[i] ? RPT_NEXT : RPT_FIRST));
    end
  end

  always_ff @(posedge clk or negedge Rst_n) begin
    if (!Rst_n) begin
      rpt_phase <= '0;
      for (int i = 0; i < 2; i++) begin
        rpt_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (!lvl[i]) begin
          rpt_cnt[i]   <= '0;
          rpt_phase[i] <= 1'b0;
        end else if (press_evt[i]) begin
          rpt_cnt[i]   <= CNT_ONE;
          rpt_phase[i] <= 1'b0;
        end else if (rpt_evt[i]) begin
          rpt_cnt[i]   <= CNT_ONE;
          rpt_phase[i] <= 1'b1;
        end else begin
          rpt_cnt[i]   <= rpt_cnt[i] + CNT_ONE;
        end
      end
    end
  end

  assign cand = press_evt | {1'b0, rpt_evt};
`else
  assign cand = press_evt;
`endif

  // Arbitration: pause > speed_up > speed_down; losers are dropped.
  always_ff @(posedge clk or negedge Rst_n) begin
    if (!Rst_n) begin
      pause      <= 1'b0;
      speed_up   <= 1'b0;
      speed_down <= 1'b0;
    end else begin
      pause      <= cand[2];
      speed_up   <= cand[0] & ~cand[2];
      speed_down <= cand[1] & ~cand[2] & ~cand[0];
    end
  end

  assign btn_level = lvl;

endmodule

// File: tb/tb_btn_pulse_gen.sv
// tb_btn_pulse_gen
//
// Self-checking bench for btn_pulse_gen with DEBOUNCE_CYCLES=4,
// REPEAT_DELAY=10, REPEAT_PERIOD=5. Expectations follow BTN_AUTO_REPEAT_EN
// when it is defined for the build.

module tb_btn_pulse_gen;

  localparam int DB = 4;
  localparam int RD = 10;
  localparam int RP = 5;

  logic       clk = 1'b0;
  logic       Rst_n;
  logic       btn_up;
  logic       btn_down;
  logic       btn_center;
  logic       speed_up;
  logic       speed_down;
  logic       pause;
  logic [2:0] btn_level;

  always #5 clk = ~clk;

  btn_pulse_gen #(
    .DEBOUNCE_CYCLES(DB),
    .REPEAT_DELAY   (RD),
    .REPEAT_PERIOD  (RP)
  ) dut (
    .clk       (clk),
    .Rst_n     (Rst_n),
    .btn_up    (btn_up),
    .btn_down  (btn_down),
    .btn_center(btn_center),
    .speed_up  (speed_up),
    .speed_down(speed_down),
    .pause     (pause),
    .btn_level (btn_level)
  );

  int n_vec = 0;
  int n_bad = 0;
  int edge_no = 0;

  // Observed outputs per edge: {btn_level[2:0], pause, speed_down, speed_up}.
  logic [5:0] obs [0:8191];

  // Reference model: raw sample history since reset, debounced levels,
  // pending candidates and the edge on which each button was last pressed.
  bit [2:0] hist [0:255];
  int       hlen;
  int       ecount;
  bit [2:0] m_lvl;
  bit [2:0] m_cand;
  bit [2:0] e_pulse;
  int       press_edge [3];

  typedef struct {
    logic [2:0] btn;
    int         cycles;
    int         exp_up;
    int         exp_dn;
    int         exp_pause;
    logic [2:0] exp_level;
  } seg_t;

  seg_t tbl [16];

  task automatic modelReset();
    m_lvl   = '0;
    m_cand  = '0;
    e_pulse = '0;
    hlen    = 0;
    ecount  = 0;
    for (int b = 0; b < 3; b++) press_edge[b] = 0;
  endtask

  // A level flips once the last DB synchronised samples (raw samples taken two
  // edges earlier, zero before reset release) all disagree with it.
  task automatic modelStep();
    bit [2:0] raw;
    bit [2:0] nl;
    bit       all_flip;
    int       idx;
    bit       s;
    raw = {btn_center, btn_down, btn_up};
    e_pulse[2] = m_cand[2];
    e_pulse[0] = m_cand[0] & ~m_cand[2];
    e_pulse[1] = m_cand[1] & ~m_cand[2] & ~m_cand[0];
    m_cand = '0;
    for (int b = 0; b < 3; b++) begin
      all_flip = 1'b1;
      for (int j = 1; j <= DB; j++) begin
        idx = hlen - 1 - j;
        s = (idx >= 0) ? hist[idx % 256][b] : 1'b0;
        if (s == m_lvl[b]) all_flip = 1'b0;
      end
      nl[b] = all_flip ? ~m_lvl[b] : m_lvl[b];
      if (nl[b] && !m_lvl[b]) begin
        m_cand[b] = 1'b1;
        press_edge[b] = ecount;
      end
`ifdef BTN_AUTO_REPEAT_EN
      else if (b != 2 && nl[b] && m_lvl[b] && (ecount - press_edge[b]) >= RD &&
               ((ecount - press_edge[b] - RD) % RP) == 0) begin
        m_cand[b] = 1'b1;
      end
`endif
    end
    hist[hlen % 256] = raw;
    hlen++;
    ecount++;
    m_lvl = nl;
  endtask

  task automatic cmpBits(input string name, input logic [2:0] got, input logic [2:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s near edge %0d: got %b, expected %b", name, edge_no - 1, got, exp);
    end
  endtask

  task automatic cmpInt(input string name, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  task automatic checkOutput();
    cmpBits("speed_up",   {2'b00, speed_up},   {2'b00, e_pulse[0]});
    cmpBits("speed_down", {2'b00, speed_down}, {2'b00, e_pulse[1]});
    cmpBits("pause",      {2'b00, pause},      {2'b00, e_pulse[2]});
    cmpBits("btn_level",  btn_level,           m_lvl);
  endtask

  task automatic applyStimulus(input logic [2:0] b, input logic r);
    {btn_center, btn_down, btn_up} = b;
    Rst_n = r;
    if (!r) begin
      modelReset();
      #1;
      checkOutput();
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (Rst_n) modelStep();
    #1;
    obs[edge_no % 8192] = {btn_level, pause, speed_down, speed_up};
    edge_no++;
    checkOutput();
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  // Compares one observed bit over a window of edges against a list of
  // relative edges where it must be high (unused slots are -1).
  task automatic checkPulses(input string name, input int bsel, input int t0, input int len,
                             input int e0, input int e1, input int e2, input int e3, input int e4);
    int bad;
    int first;
    bit gotb;
    bit expb;
    bit fgot;
    bit fexp;
    bad = 0;
    first = -1;
    fgot = 1'b0;
    fexp = 1'b0;
    for (int r = 0; r < len; r++) begin
      expb = (r == e0) || (r == e1) || (r == e2) || (r == e3) || (r == e4);
      gotb = obs[(t0 + r) % 8192][bsel];
      if (gotb != expb) begin
        if (bad == 0) begin
          first = r;
          fgot = gotb;
          fexp = expb;
        end
        bad++;
      end
    end
    n_vec++;
    if (bad != 0) begin
      n_bad++;
      $display("[TB] FAIL %s: %0d wrong edges, first at relative edge %0d got %0b expected %0b",
               name, bad, first, fgot, fexp);
    end
  endtask

  initial begin
    int t0;
    int cu;
    int cd;
    int cp;
    int dur [3];
    logic [2:0] cur;

    tbl = '{
      '{3'b001, 8, 1, 0, 0, 3'b001}, '{3'b000, 8, 0, 0, 0, 3'b000},
      '{3'b010, 8, 0, 1, 0, 3'b010}, '{3'b000, 8, 0, 0, 0, 3'b000},
      '{3'b100, 8, 0, 0, 1, 3'b100}, '{3'b000, 8, 0, 0, 0, 3'b000},
      '{3'b011, 8, 1, 0, 0, 3'b011}, '{3'b000, 8, 0, 0, 0, 3'b000},
      '{3'b110, 8, 0, 0, 1, 3'b110}, '{3'b000, 8, 0, 0, 0, 3'b000},
      '{3'b101, 8, 0, 0, 1, 3'b101}, '{3'b000, 8, 0, 0, 0, 3'b000},
      '{3'b111, 8, 0, 0, 1, 3'b111}, '{3'b000, 8, 0, 0, 0, 3'b000},
      '{3'b001, 3, 0, 0, 0, 3'b000}, '{3'b000, 8, 0, 0, 0, 3'b000}
    };

    // Reset state.
    applyStimulus(3'b000, 1'b0);
    ticks(3);
    applyStimulus(3'b000, 1'b1);
    ticks(4);

    // Table of press/release segments: count pulses and check final level.
    for (int s = 0; s < 16; s++) begin
      cu = 0;
      cd = 0;
      cp = 0;
      applyStimulus(tbl[s].btn, 1'b1);
      for (int k = 0; k < tbl[s].cycles; k++) begin
        tick();
        cu += int'(speed_up);
        cd += int'(speed_down);
        cp += int'(pause);
      end
      cmpInt($sformatf("seg%0d_up_count", s), cu, tbl[s].exp_up);
      cmpInt($sformatf("seg%0d_down_count", s), cd, tbl[s].exp_dn);
      cmpInt($sformatf("seg%0d_pause_count", s), cp, tbl[s].exp_pause);
      cmpBits($sformatf("seg%0d_level", s), btn_level, tbl[s].exp_level);
    end

    // Clean press: level at edge 5, pulse at edge 6.
    t0 = edge_no;
    applyStimulus(3'b001, 1'b1);
    ticks(20);
    applyStimulus(3'b000, 1'b1);
    ticks(10);
`ifdef BTN_AUTO_REPEAT_EN
    checkPulses("clean_speed_up", 0, t0, 30, 6, 16, 21, -1, -1);
`else
    checkPulses("clean_speed_up", 0, t0, 30, 6, -1, -1, -1, -1);
`endif
    checkPulses("clean_speed_down", 1, t0, 30, -1, -1, -1, -1, -1);
    checkPulses("clean_pause", 2, t0, 30, -1, -1, -1, -1, -1);
    cmpBits("clean_level_edge4", {2'b00, obs[(t0 + 4) % 8192][3]}, 3'b000);
    cmpBits("clean_level_edge5", {2'b00, obs[(t0 + 5) % 8192][3]}, 3'b001);

    // Glitch rejection.
    t0 = edge_no;
    applyStimulus(3'b010, 1'b1);
    ticks(3);
    applyStimulus(3'b000, 1'b1);
    ticks(5);
    applyStimulus(3'b010, 1'b1);
    ticks(3);
    applyStimulus(3'b000, 1'b1);
    ticks(10);
    checkPulses("glitch_speed_down", 1, t0, 21, -1, -1, -1, -1, -1);
    checkPulses("glitch_level_down", 4, t0, 21, -1, -1, -1, -1, -1);

    // Bounce then settle: final high run starts at relative edge 10.
    t0 = edge_no;
    for (int k = 0; k < 10; k++) begin
      applyStimulus((k % 2 == 0) ? 3'b100 : 3'b000, 1'b1);
      tick();
    end
    applyStimulus(3'b100, 1'b1);
    ticks(20);
    applyStimulus(3'b000, 1'b1);
    ticks(10);
    checkPulses("bounce_pause", 2, t0, 40, 16, -1, -1, -1, -1);
    cmpBits("bounce_level_edge14", {obs[(t0 + 14) % 8192][5], 2'b00}, 3'b000);
    cmpBits("bounce_level_edge15", {obs[(t0 + 15) % 8192][5], 2'b00}, 3'b100);

    // Simultaneous up + centre.
    t0 = edge_no;
    applyStimulus(3'b101, 1'b1);
    ticks(8);
    applyStimulus(3'b000, 1'b1);
    ticks(12);
    checkPulses("simul_pause", 2, t0, 20, 6, -1, -1, -1, -1);
    checkPulses("simul_speed_up", 0, t0, 20, -1, -1, -1, -1, -1);

    // Reset mid-press: reset after edge 3 for two edges; edge 6 is the first
    // post-reset sampling edge, so the pulse lands on relative edge 12.
    t0 = edge_no;
    applyStimulus(3'b010, 1'b1);
    ticks(4);
    applyStimulus(3'b010, 1'b0);
    ticks(2);
    applyStimulus(3'b010, 1'b1);
    ticks(10);
    applyStimulus(3'b000, 1'b1);
    ticks(10);
    checkPulses("reset_speed_down", 1, t0, 26, 12, -1, -1, -1, -1);
    cmpBits("reset_outputs_edge5", obs[(t0 + 5) % 8192][5:3] | obs[(t0 + 5) % 8192][2:0], 3'b000);

    // Long hold: auto-repeat schedule when enabled, single pulse otherwise.
    t0 = edge_no;
    applyStimulus(3'b001, 1'b1);
    ticks(30);
    applyStimulus(3'b000, 1'b1);
    ticks(15);
`ifdef BTN_AUTO_REPEAT_EN
    checkPulses("repeat_speed_up", 0, t0, 45, 6, 16, 21, 26, 31);
`else
    checkPulses("repeat_speed_up", 0, t0, 45, 6, -1, -1, -1, -1);
`endif

    // Randomised hold/release runs with occasional resets, checked per cycle
    // against the reference model.
    for (int b = 0; b < 3; b++) dur[b] = 0;
    cur = '0;
    for (int c = 0; c < 3000; c++) begin
      for (int b = 0; b < 3; b++) begin
        if (dur[b] == 0) begin
          cur[b] = 1'($urandom_range(0, 1));
          dur[b] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 40)) : int'($urandom_range(1, 10));
        end
        dur[b]--;
      end
      if ($urandom_range(0, 299) == 0) begin
        applyStimulus(cur, 1'b0);
        ticks(2);
      end
      applyStimulus(cur, 1'b1);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/btn_pulse_gen.md
# btn_pulse_gen

- Conditions the three raw push-button inputs (up, down, centre) into clean single-cycle command pulses.
- Drives the `speed_up`, `speed_down` and `pause` inputs of the address-sequencing control stage.
- Per button: synchronises the asynchronous input, debounces it with a consecutive-cycle counter and emits one pulse per debounced press.
- Arbitrates so at most one command pulse is high in any cycle.

## Interface

Parameters:
- `DEBOUNCE_CYCLES`, 2_000_000: consecutive synchronised cycles a new level must hold before it is accepted (20 ms at 100 MHz); legal range ≥ 2.
- `REPEAT_DELAY`, 50_000_000: cycles from the first pulse of a held press to the first auto-repeat pulse; legal range ≥ 2.
- `REPEAT_PERIOD`, 25_000_000: cycles between subsequent auto-repeat pulses; legal range ≥ 2.

Ports:
- `clk` input 1: single system clock; all state is on its rising edge.
- `Rst_n` input 1: asynchronous, active-low reset.
- `btn_up` input 1: raw up button, active-high, asynchronous to `clk`.
- `btn_down` input 1: raw down button, active-high, asynchronous.
- `btn_center` input 1: raw centre button, active-high, asynchronous.
- `speed_up` output 1: one-cycle command pulse.
- `speed_down` output 1: one-cycle command pulse.
- `pause` output 1: one-cycle command pulse.
- `btn_level` output 3: debounced levels `{center, down, up}`.

## Operation

- **Synchroniser:** two-flop synchroniser per button; only the second flop (`sync`) is used downstream.
- **Debounce state per button:** stable level `lvl`, counter `cnt`.
  - `cnt` width = `$clog2(max(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD)) + 1`.
  - `sync == lvl`: `cnt <= 0`.
  - `sync != lvl` and `cnt == DEBOUNCE_CYCLES-1`: `lvl <= sync`, `cnt <= 0`.
  - Otherwise: `cnt <= cnt + 1`.
  - Any single matching sample restarts the count, so glitches shorter than `DEBOUNCE_CYCLES` synchronised cycles are discarded.
- **Press event:** a 0→1 transition of `lvl`. Release (1→0) produces no event.
- **Arbitration:** candidate events in the same cycle are resolved with priority `pause` > `speed_up` > `speed_down`. Losing events are dropped, not queued.
- **Outputs:** all outputs are registered. `btn_level` mirrors `lvl`.
- **Reset:** asserting `Rst_n` low at any time immediately clears synchronisers, `lvl`, counters, repeat timers, all pulses and `btn_level` to 0.
  - A button still held when reset is released is treated as a new press. It is debounced from scratch and produces one pulse.

## Timing

- Edge 0 is the first rising edge that samples a raw input high; the input is held from then on.
  - `sync` is high after edge 1.
  - `lvl` and `btn_level` bit go high at edge `DEBOUNCE_CYCLES+1`.
  - The command pulse is high from edge `DEBOUNCE_CYCLES+2` to edge `DEBOUNCE_CYCLES+3`, exactly one cycle wide.
- Release follows the same timing: `lvl` falls `DEBOUNCE_CYCLES+1` edges after the first low sample. No pulse is generated.
- **Back-to-back presses:** a new pulse requires `lvl` to return to 0 and rise again. The minimum press-to-press spacing is therefore about `2*DEBOUNCE_CYCLES+2` cycles.
- There is no handshake. The consumer must sample every cycle, and a pulse is never stretched or held.

## Configuration

- Macro `BTN_AUTO_REPEAT_EN`.
- **Defined:** while `lvl` of `btn_up` or `btn_down` stays 1:
  - A repeat pulse is emitted `REPEAT_DELAY` cycles after the initial pulse.
  - Further repeat pulses follow every `REPEAT_PERIOD` cycles.
  - The repeat timer stops and clears when `lvl` falls.
  - Repeat pulses go through the same arbitration; a dropped repeat does not shift the schedule.
  - `btn_center` never repeats.
- **Undefined:** no repeat logic is built. Each debounced press yields exactly one pulse. `REPEAT_DELAY` and `REPEAT_PERIOD` remain declared but are unused.

## Test plan

All scenarios use `DEBOUNCE_CYCLES=4`.

- **Clean press:** `btn_up` rises before edge 0 and is held 20 cycles → `btn_level[0]` = 1 from edge 5; `speed_up` high only between edges 6 and 7; no other pulse.
- **Glitch rejection:** `btn_down` high for 3 cycles, low 5, high 3 → no `speed_down` pulse; `btn_level` stays 0.
- **Bounce then settle:** `btn_center` toggles every cycle for 10 cycles, then holds high → exactly one `pause` pulse, 6 edges after the first sample of the final high run.
- **Simultaneous press:** `btn_up` and `btn_center` rise on the same cycle → one `pause` pulse; `speed_up` stays 0 throughout.
- **Reset mid-press:** `btn_down` is held; `Rst_n` is pulsed low at edge 3 for 2 cycles → all outputs read 0 during reset; one `speed_down` pulse 6 edges after the first post-reset sampling edge.
- **Auto-repeat (`BTN_AUTO_REPEAT_EN` defined, `REPEAT_DELAY=10`, `REPEAT_PERIOD=5`):** `btn_up` held 30 cycles → `speed_up` pulses at edges 6, 16, 21, 26, 31, then stops within `DEBOUNCE_CYCLES+1` cycles of release.
  - With the macro undefined, the same stimulus gives a pulse at edge 6 only.
